fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage 16-bit pipeline. It sits directly upstream of the IF/ID pipeline register and owns the PC. It issues reads to the instruction memory/cache, absorbs variable memory latency, and honours decode-stage stalls and execute-stage redirects. Each cycle it presents either a valid instruction with its PC+2, or a NOP.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/register.sv | 21 ++
 rtl/fetch_stage.sv | 153 +++++++++++++++
 tb/tb_fetch_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN = 16;
    localparam logic [XLEN-1:0] NOP_INSTR = 16'h0800;
    localparam logic [4:0] HALT_OPC = 5'b00000;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_WAIT,
        ST_HOLD,
        ST_HALTED
    } fetch_state_t;

    // A word whose top five bits carry the HALT opcode freezes fetch.
    function automatic logic is_halt(input logic [XLEN-1:0] word);
        return word[XLEN-1 -: 5] == HALT_OPC;
    endfunction

endpackage

// File: rtl/register.sv
// Generic enabled register with asynchronous active-high reset to a parameterised value.
module register #(
    parameter int unsigned W = 16,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, absorbs memory latency, honours stalls and redirects.
// Optional memory-wait counter and stall_cnt port enabled by FETCH_STALL_CNT_EN.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 16'h0000,
    parameter int unsigned     CNT_W    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            mem_done,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            mem_rd,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc_add2,
    output logic            instr_valid,
    output logic            halted
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic            pc_en;
    logic [XLEN-1:0] hold_buf, hold_nxt;
    logic [XLEN-1:0] pend_pc, pend_pc_nxt;
    logic            pend, pend_nxt;

    register #(.W(XLEN), .RESET_VAL(RESET_PC)) u_pc (
        .clk (clk),
        .rst (rst),
        .en  (pc_en),
        .d   (pc_nxt),
        .q   (pc)
    );

    assign pc_add2  = pc + XLEN'(2);
    assign mem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_FETCH;
            hold_buf <= NOP_INSTR;
            pend     <= 1'b0;
            pend_pc  <= RESET_PC;
        end else begin
            state    <= state_nxt;
            hold_buf <= hold_nxt;
            pend     <= pend_nxt;
            pend_pc  <= pend_pc_nxt;
        end
    end

    // Next-state, next-PC and presented-instruction logic.
    always_comb begin
        state_nxt   = state;
        pc_en       = 1'b0;
        pc_nxt      = pc_add2;
        hold_nxt    = hold_buf;
        pend_nxt    = pend;
        pend_pc_nxt = pend_pc;
        mem_rd      = 1'b0;
        instr       = NOP_INSTR;
        instr_valid = 1'b0;
        halted      = 1'b0;

        case (state)
            ST_FETCH, ST_WAIT: begin
                mem_rd = 1'b1;
                if (!mem_done) begin
                    // Access in flight cannot be aborted; remember the latest target.
                    state_nxt = ST_WAIT;
                    if (redirect) begin
                        pend_nxt    = 1'b1;
                        pend_pc_nxt = redirect_pc;
                    end
                end else if (redirect || pend) begin
                    state_nxt = ST_FETCH;
                    pc_en     = 1'b1;
                    pc_nxt    = redirect ? redirect_pc : pend_pc;
                    pend_nxt  = 1'b0;
                end else begin
                    instr       = mem_rdata;
                    instr_valid = 1'b1;
                    if (stall) begin
                        hold_nxt  = mem_rdata;
                        state_nxt = ST_HOLD;
                    end else if (is_halt(mem_rdata)) begin
                        state_nxt = ST_HALTED;
                    end else begin
                        pc_en     = 1'b1;
                        state_nxt = ST_FETCH;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_en     = 1'b1;
                    pc_nxt    = redirect_pc;
                    state_nxt = ST_FETCH;
                end else begin
                    instr       = hold_buf;
                    instr_valid = 1'b1;
                    if (!stall) begin
                        if (is_halt(hold_buf)) begin
                            state_nxt = ST_HALTED;
                        end else begin
                            pc_en     = 1'b1;
                            state_nxt = ST_FETCH;
                        end
                    end
                end
            end
            ST_HALTED: begin
                halted = 1'b1;
                if (redirect) begin
                    pc_en     = 1'b1;
                    pc_nxt    = redirect_pc;
                    state_nxt = ST_FETCH;
                end
            end
            default: begin
                state_nxt = ST_FETCH;
            end
        endcase

        // Nothing is requested or presented while reset is held.
        if (rst) begin
            mem_rd      = 1'b0;
            instr       = NOP_INSTR;
            instr_valid = 1'b0;
            halted      = 1'b0;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    // Saturating count of cycles spent waiting on instruction memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (mem_rd && !mem_done && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expectations queued at drive time, compared at the falling edge.
module tb_fetch_stage;

    localparam logic [15:0] NOP = 16'h0800;

    typedef struct {
        logic        rd;
        logic [15:0] addr;
        logic        v;
        logic [15:0] ins;
        logic [15:0] add2;
        logic        hlt;
        logic [31:0] cnt;
        logic        chk2;
        logic [15:0] addr2;
        logic [15:0] add2_2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        mem_done = 1'b1;
    logic [15:0] mem_rdata;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [15:0] instr;
    logic [15:0] pc_add2;
    logic        instr_valid;
    logic        halted;

    logic [15:0] mem_rdata2;
    logic        mem_rd2;
    logic [15:0] mem_addr2;
    logic [15:0] instr2;
    logic [15:0] pc_add2_2;
    logic        instr_valid2;
    logic        halted2;

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] stall_cnt2;
`endif

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    // Instruction memory image: HALT at 0x000A, otherwise a non-HALT word tagged with its address.
    function automatic logic [15:0] word_of(input logic [15:0] a);
        if (a == 16'h000A) return 16'h0000;
        return {5'b00011, a[10:0]};
    endfunction

    assign mem_rdata  = word_of(mem_addr);
    assign mem_rdata2 = word_of(mem_addr2);

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_done    (mem_done),
        .mem_rdata   (mem_rdata),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .instr       (instr),
        .pc_add2     (pc_add2),
        .instr_valid (instr_valid),
        .halted      (halted)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    fetch_stage #(.RESET_PC(16'hFFFE)) dut_wrap (
        .clk         (clk),
        .rst         (rst),
        .stall       (1'b0),
        .redirect    (1'b0),
        .redirect_pc (16'h0000),
        .mem_done    (1'b1),
        .mem_rdata   (mem_rdata2),
        .mem_rd      (mem_rd2),
        .mem_addr    (mem_addr2),
        .instr       (instr2),
        .pc_add2     (pc_add2_2),
        .instr_valid (instr_valid2),
        .halted      (halted2)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic rd, input logic [15:0] addr, input logic v,
                                input logic [15:0] ins, input logic [15:0] add2,
                                input logic hlt, input logic [31:0] cnt);
        exp_t e;
        e.rd = rd; e.addr = addr; e.v = v; e.ins = ins; e.add2 = add2;
        e.hlt = hlt; e.cnt = cnt; e.chk2 = 1'b0; e.addr2 = '0; e.add2_2 = '0;
        return e;
    endfunction

    task automatic step(input logic r, input logic d, input logic s, input logic rr,
                        input logic [15:0] rpc, input exp_t e);
        @(posedge clk);
        #1;
        rst = r; mem_done = d; stall = s; redirect = rr; redirect_pc = rpc;
        sb.push_back(e);
    endtask

    // Compare presented outputs against the oldest queued expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("mem_rd",      32'(mem_rd),      32'(e.rd));
            check("mem_addr",    32'(mem_addr),    32'(e.addr));
            check("instr_valid", 32'(instr_valid), 32'(e.v));
            check("instr",       32'(instr),       32'(e.ins));
            check("pc_add2",     32'(pc_add2),     32'(e.add2));
            check("halted",      32'(halted),      32'(e.hlt));
`ifdef FETCH_STALL_CNT_EN
            check("stall_cnt",   stall_cnt,        e.cnt);
`endif
            if (e.chk2) begin
                check("wrap_addr",  32'(mem_addr2), 32'(e.addr2));
                check("wrap_add2",  32'(pc_add2_2), 32'(e.add2_2));
                check("wrap_valid", 32'(instr_valid2), 32'(1'b1));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;

        step(1, 1, 0, 0, 16'h0, mk(0, 16'h0000, 0, NOP, 16'h0002, 0, 0));

        // Back-to-back hits from reset; wrap instance checks 0xFFFE -> 0x0000.
        e = mk(1, 16'h0000, 1, word_of(16'h0000), 16'h0002, 0, 0);
        e.chk2 = 1'b1; e.addr2 = 16'hFFFE; e.add2_2 = 16'h0000;
        step(0, 1, 0, 0, 16'h0, e);
        e = mk(1, 16'h0002, 1, word_of(16'h0002), 16'h0004, 0, 0);
        e.chk2 = 1'b1; e.addr2 = 16'h0000; e.add2_2 = 16'h0002;
        step(0, 1, 0, 0, 16'h0, e);

        // Three-cycle miss at 0x0004.
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 0, 16'h0, mk(1, 16'h0004, 0, NOP, 16'h0006, 0, 32'(i)));
        step(0, 1, 0, 0, 16'h0, mk(1, 16'h0004, 1, word_of(16'h0004), 16'h0006, 0, 3));

        // Delivery under stall, held for two cycles, then released.
        step(0, 1, 1, 0, 16'h0, mk(1, 16'h0006, 1, word_of(16'h0006), 16'h0008, 0, 3));
        step(0, 1, 1, 0, 16'h0, mk(0, 16'h0006, 1, word_of(16'h0006), 16'h0008, 0, 3));
        step(0, 1, 0, 0, 16'h0, mk(0, 16'h0006, 1, word_of(16'h0006), 16'h0008, 0, 3));

        // Redirect during a wait becomes pending; returned word is dropped.
        step(0, 0, 0, 1, 16'h0100, mk(1, 16'h0008, 0, NOP, 16'h000A, 0, 3));
        step(0, 1, 0, 0, 16'h0,    mk(1, 16'h0008, 0, NOP, 16'h000A, 0, 4));
        step(0, 1, 0, 0, 16'h0,    mk(1, 16'h0100, 1, word_of(16'h0100), 16'h0102, 0, 4));

        // Redirect on a hit, with stall also asserted: redirect wins.
        step(0, 1, 1, 1, 16'h0008, mk(1, 16'h0102, 0, NOP, 16'h0104, 0, 4));
        step(0, 1, 0, 0, 16'h0,    mk(1, 16'h0008, 1, word_of(16'h0008), 16'h000A, 0, 4));

        // HALT word at 0x000A, frozen until redirect to 0x0020.
        step(0, 1, 0, 0, 16'h0, mk(1, 16'h000A, 1, 16'h0000, 16'h000C, 0, 4));
        for (int i = 0; i < 4; i++)
            step(0, 1, 0, 0, 16'h0, mk(0, 16'h000A, 0, NOP, 16'h000C, 1, 4));
        step(0, 1, 0, 1, 16'h0020, mk(0, 16'h000A, 0, NOP, 16'h000C, 1, 4));
        step(0, 1, 0, 0, 16'h0,    mk(1, 16'h0020, 1, word_of(16'h0020), 16'h0022, 0, 4));

        // Second redirect while pending overwrites the target.
        step(0, 0, 0, 1, 16'h0040, mk(1, 16'h0022, 0, NOP, 16'h0024, 0, 4));
        step(0, 0, 0, 1, 16'h0060, mk(1, 16'h0022, 0, NOP, 16'h0024, 0, 5));
        step(0, 1, 0, 0, 16'h0,    mk(1, 16'h0022, 0, NOP, 16'h0024, 0, 6));
        step(0, 1, 0, 0, 16'h0,    mk(1, 16'h0060, 1, word_of(16'h0060), 16'h0062, 0, 6));

        // Asynchronous reset in the middle of a wait.
        step(0, 0, 0, 0, 16'h0, mk(1, 16'h0062, 0, NOP, 16'h0064, 0, 6));
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_mem_rd",  32'(mem_rd),      32'(1'b0));
        check("arst_addr",    32'(mem_addr),    32'(16'h0000));
        check("arst_instr",   32'(instr),       32'(NOP));
        check("arst_valid",   32'(instr_valid), 32'(1'b0));
        check("arst_add2",    32'(pc_add2),     32'(16'h0002));
        check("arst_halted",  32'(halted),      32'(1'b0));
`ifdef FETCH_STALL_CNT_EN
        check("arst_cnt",     stall_cnt,        32'd0);
`endif
        check("arst_wrap_addr", 32'(mem_addr2), 32'(16'hFFFE));
        check("arst_wrap_add2", 32'(pc_add2_2), 32'(16'h0000));

        // Late response during reset is ignored; fetch restarts at RESET_PC.
        step(1, 1, 0, 0, 16'h0, mk(0, 16'h0000, 0, NOP, 16'h0002, 0, 0));
        step(0, 1, 0, 0, 16'h0, mk(1, 16'h0000, 1, word_of(16'h0000), 16'h0002, 0, 0));
        step(0, 1, 0, 0, 16'h0, mk(1, 16'h0002, 1, word_of(16'h0002), 16'h0004, 0, 0));

        @(negedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
